// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared sizing constants for the shift-and-add multiplier.
package seq_mult_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int CNT_W     = $clog2(DEF_WIDTH + 1);
   localparam int PROD_W    = 2 * DEF_WIDTH;
endpackage

// File: rtl/seq_shift_add_mult_if.sv
// seq_shift_add_mult_if: load/operand/result bundle for the sequential multiplier.
interface seq_shift_add_mult_if
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic               load;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [2*WIDTH-1:0] op;
   logic               valid;
   modport master (output load, a, b, input op, valid);
   modport slave  (input load, a, b, output op, valid);
endinterface

// File: rtl/seq_mult_adder.sv
// seq_mult_adder: combinational unsigned adder with carry-out.
module seq_mult_adder
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] s,
   output logic             c
);
   assign {c, s} = {1'b0, x} + {1'b0, y};
endmodule

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: unsigned WIDTHxWIDTH multiplier, one shift-and-add step per clock.
module seq_shift_add_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic clk,
   input  logic reset,
   seq_shift_add_mult_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   logic [WIDTH-1:0] mcand, mplier, hi, lo, pp, s;
   logic             c, vld;
   logic [CW-1:0]    cnt;
   assign pp = mcand & {WIDTH{mplier[0]}};
   seq_mult_adder #(.WIDTH(WIDTH)) u_add (.x(hi), .y(pp), .s(s), .c(c));
   // The sum's carry and low bit are shifted into the product halves each step
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand  <= '0;
         mplier <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         vld    <= 1'b0;
      end else if (bus.load) begin
         mcand  <= bus.a;
         mplier <= bus.b;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         vld    <= 1'b0;
      end else if (!vld && cnt < CW'(WIDTH)) begin
         hi     <= {c, s[WIDTH-1:1]};
         lo     <= {s[0], lo[WIDTH-1:1]};
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         vld    <= (cnt == CW'(WIDTH - 1));
      end
   end
   assign bus.op    = {hi, lo};
   assign bus.valid = vld;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: directed scoreboard bench for the sequential multiplier.
module tb_seq_shift_add_mult;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int vectors = 0;
   int miscompares = 0;
   logic [15:0] q[$];
   seq_shift_add_mult_if #(.WIDTH(8)) bus ();
   seq_shift_add_mult #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Called at a negedge: holds load for one posedge, then returns at the next negedge
   task automatic do_load(input logic [7:0] a, input logic [7:0] b);
      bus.load = 1'b1;
      bus.a = a;
      bus.b = b;
      @(negedge clk);
      bus.load = 1'b0;
      q.push_back(16'(a) * 16'(b));
   endtask
   task automatic wait_done(input string tag);
      int n;
      logic [15:0] e;
      n = 0;
      while (!bus.valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'd8);
      e = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
      chk({tag, "_op"}, 32'(bus.op), 32'(e));
      chk({tag, "_valid"}, 32'(bus.valid), 32'd1);
   endtask
   initial begin
      int n;
      bus.load = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(negedge clk);
      chk("rst_op", 32'(bus.op), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      reset = 1'b1;
      repeat (7) @(negedge clk);
      chk("idle_valid7", 32'(bus.valid), 32'd0);
      @(negedge clk);
      chk("idle_valid8", 32'(bus.valid), 32'd1);
      chk("idle_op", 32'(bus.op), 32'd0);
      do_load(8'd13, 8'd11);
      chk("m143_vlow", 32'(bus.valid), 32'd0);
      wait_done("m143");
      repeat (20) @(negedge clk);
      chk("hold_op", 32'(bus.op), 32'd143);
      chk("hold_valid", 32'(bus.valid), 32'd1);
      do_load(8'd255, 8'd255);
      wait_done("m255");
      do_load(8'd0, 8'd200);
      wait_done("m0");
      do_load(8'd1, 8'd128);
      wait_done("m128");
      do_load(8'd128, 8'd2);
      wait_done("m256");
      do_load(8'd7, 8'd9);
      repeat (3) @(negedge clk);
      q.delete();
      do_load(8'd20, 8'd30);
      chk("restart_vlow", 32'(bus.valid), 32'd0);
      wait_done("restart");
      do_load(8'd100, 8'd50);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("arst_op", 32'(bus.op), 32'd0);
      chk("arst_valid", 32'(bus.valid), 32'd0);
      q.delete();
      @(negedge clk);
      reset = 1'b1;
      do_load(8'd3, 8'd5);
      wait_done("m15");
      do_load(8'd6, 8'd7);
      wait_done("m42");
      do_load(8'd200, 8'd3);
      chk("b2b_vlow", 32'(bus.valid), 32'd0);
      wait_done("b2b");
      n = q.size();
      chk("sb_empty", 32'(n), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
